// File: rtl/ibex_trap_controller_if.sv
// IF/ID trap controller port bundle: decoder/LSU/interrupt inputs and redirect/CSR strobes.
// master = controller side, slave = the pipeline and interrupt sources around it.
interface ibex_trap_controller_if #(
  parameter int NUM_FAST_IRQ = 15
);
  logic                    fetch_enable_i;
  logic                    instr_valid_i;
  logic                    illegal_insn_i;
  logic                    ecall_insn_i;
  logic                    mret_insn_i;
  logic                    wfi_insn_i;
  logic                    instr_fetch_err_i;
  logic                    branch_set_i;
  logic                    stall_i;
  logic                    load_err_i;
  logic                    store_err_i;
  logic [31:0]             lsu_addr_last_i;
  logic [31:0]             pc_id_i;
  logic [31:0]             instr_i;
  logic                    csr_mstatus_mie_i;
  logic                    irq_software_i;
  logic                    irq_timer_i;
  logic                    irq_external_i;
  logic [NUM_FAST_IRQ-1:0] irq_fast_i;
  logic                    irq_nm_i;

  logic                    ctrl_busy_o;
  logic                    instr_req_o;
  logic                    pc_set_o;
  logic [2:0]              pc_mux_o;
  logic [5:0]              exc_cause_o;
  logic                    csr_save_if_o;
  logic                    csr_save_id_o;
  logic                    csr_save_cause_o;
  logic                    csr_restore_mret_o;
  logic [31:0]             csr_mtval_o;
  logic                    id_in_ready_o;
  logic                    instr_valid_clear_o;
  logic                    nmi_mode_o;
  logic                    irq_ack_o;
  logic [4:0]              irq_ack_id_o;

  modport master (
    input  fetch_enable_i, instr_valid_i, illegal_insn_i, ecall_insn_i, mret_insn_i,
           wfi_insn_i, instr_fetch_err_i, branch_set_i, stall_i, load_err_i, store_err_i,
           lsu_addr_last_i, pc_id_i, instr_i, csr_mstatus_mie_i, irq_software_i,
           irq_timer_i, irq_external_i, irq_fast_i, irq_nm_i,
    output ctrl_busy_o, instr_req_o, pc_set_o, pc_mux_o, exc_cause_o, csr_save_if_o,
           csr_save_id_o, csr_save_cause_o, csr_restore_mret_o, csr_mtval_o,
           id_in_ready_o, instr_valid_clear_o, nmi_mode_o, irq_ack_o, irq_ack_id_o
  );

  modport slave (
    output fetch_enable_i, instr_valid_i, illegal_insn_i, ecall_insn_i, mret_insn_i,
           wfi_insn_i, instr_fetch_err_i, branch_set_i, stall_i, load_err_i, store_err_i,
           lsu_addr_last_i, pc_id_i, instr_i, csr_mstatus_mie_i, irq_software_i,
           irq_timer_i, irq_external_i, irq_fast_i, irq_nm_i,
    input  ctrl_busy_o, instr_req_o, pc_set_o, pc_mux_o, exc_cause_o, csr_save_if_o,
           csr_save_id_o, csr_save_cause_o, csr_restore_mret_o, csr_mtval_o,
           id_in_ready_o, instr_valid_clear_o, nmi_mode_o, irq_ack_o, irq_ack_id_o
  );
endinterface

// File: rtl/ibex_trap_controller.sv
// IF/ID trap controller: boot, exception/interrupt entry, mret and wfi sleep sequencing,
// with fixed or round-robin fast-interrupt arbitration and an interrupt acknowledge pulse.
module ibex_trap_controller #(
  parameter int NUM_FAST_IRQ = 15,
  parameter bit FAST_IRQ_RR  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  ibex_trap_controller_if.master bus
);
  localparam logic [2:0] PC_BOOT = 3'd0, PC_JUMP = 3'd1, PC_EXC = 3'd2, PC_ERET = 3'd3;

  typedef enum logic [2:0] {
    RESET, BOOT_SET, FIRST_FETCH, DECODE, FLUSH, IRQ_TAKEN, WAIT_SLEEP, SLEEP
  } state_e;

  state_e      state_q, state_d;
  logic        nmi_mode_q, nmi_mode_d;
  logic [3:0]  rr_ptr_q, rr_ptr_d;
  logic        exc_req_q, illegal_q, ecall_q, fetch_err_q, mret_q, wfi_q;
  logic        load_err_q, store_err_q;

  logic        in_flush, valid, exc_req, special_req, handle_irq, nmi_take, irq_std;
  logic        fast_any, halt_if, flush_id;
  logic [15:0] fast_vec;
  logic [3:0]  fast_id, idx;

  logic        instr_req, ctrl_busy, pc_set, save_if, save_id, save_cause, restore_mret, irq_ack;
  logic [2:0]  pc_mux;
  logic [5:0]  exc_cause;
  logic [31:0] mtval;

  assign valid       = bus.instr_valid_i;
  assign in_flush    = (state_q == FLUSH);
  assign exc_req     = valid & (bus.illegal_insn_i | bus.ecall_insn_i | bus.instr_fetch_err_i);
  assign special_req = (valid & (bus.mret_insn_i | bus.wfi_insn_i)) | exc_req |
                       bus.load_err_i | bus.store_err_i;

  assign fast_vec   = 16'(bus.irq_fast_i);
  assign fast_any   = |bus.irq_fast_i;
  assign irq_std    = bus.irq_software_i | bus.irq_timer_i | bus.irq_external_i | fast_any;
  assign nmi_take   = bus.irq_nm_i & ~nmi_mode_q;
  assign handle_irq = nmi_take | (bus.csr_mstatus_mie_i & irq_std);

  // Round-robin walks downward so the index closest above rr_ptr_q is assigned last and wins.
  always_comb begin
    fast_id = '0;
    idx     = '0;
    if (FAST_IRQ_RR) begin
      for (int k = NUM_FAST_IRQ; k >= 1; k--) begin
        idx = 4'((int'(rr_ptr_q) + k) % NUM_FAST_IRQ);
        if (fast_vec[idx]) fast_id = idx;
      end
    end else begin
      for (int i = 0; i < NUM_FAST_IRQ; i++)
        if (fast_vec[4'(i)]) fast_id = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q     <= RESET;
      nmi_mode_q  <= 1'b0;
      rr_ptr_q    <= 4'(NUM_FAST_IRQ - 1);
      exc_req_q   <= 1'b0;
      illegal_q   <= 1'b0;
      ecall_q     <= 1'b0;
      fetch_err_q <= 1'b0;
      mret_q      <= 1'b0;
      wfi_q       <= 1'b0;
      load_err_q  <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nmi_mode_q  <= nmi_mode_d;
      rr_ptr_q    <= rr_ptr_d;
      exc_req_q   <= exc_req & ~in_flush;
      illegal_q   <= valid & bus.illegal_insn_i & ~in_flush;
      ecall_q     <= valid & bus.ecall_insn_i & ~in_flush;
      fetch_err_q <= valid & bus.instr_fetch_err_i & ~in_flush;
      mret_q      <= valid & bus.mret_insn_i;
      wfi_q       <= valid & bus.wfi_insn_i;
      load_err_q  <= bus.load_err_i;
      store_err_q <= bus.store_err_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    nmi_mode_d   = nmi_mode_q;
    rr_ptr_d     = rr_ptr_q;
    instr_req    = 1'b1;
    ctrl_busy    = 1'b1;
    pc_set       = 1'b0;
    pc_mux       = PC_BOOT;
    exc_cause    = '0;
    save_if      = 1'b0;
    save_id      = 1'b0;
    save_cause   = 1'b0;
    restore_mret = 1'b0;
    mtval        = '0;
    halt_if      = 1'b0;
    flush_id     = 1'b0;
    irq_ack      = 1'b0;
    case (state_q)
      RESET: begin
        instr_req = 1'b0;
        pc_set    = 1'b1;
        if (bus.fetch_enable_i) state_d = BOOT_SET;
      end
      BOOT_SET: begin
        pc_set  = 1'b1;
        state_d = FIRST_FETCH;
      end
      FIRST_FETCH: begin
        if (handle_irq) begin
          state_d  = IRQ_TAKEN;
          halt_if  = 1'b1;
          flush_id = 1'b1;
        end else if (!bus.stall_i) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (valid && special_req) begin
          state_d = FLUSH;
          halt_if = 1'b1;
        end else if (bus.branch_set_i) begin
          pc_set = 1'b1;
          pc_mux = PC_JUMP;
        end
        if (!bus.stall_i && !special_req && handle_irq) begin
          state_d  = IRQ_TAKEN;
          halt_if  = 1'b1;
          flush_id = 1'b1;
        end
      end
      FLUSH: begin
        halt_if  = 1'b1;
        flush_id = 1'b1;
        state_d  = DECODE;
        if (exc_req_q || load_err_q || store_err_q) begin
          pc_set     = 1'b1;
          pc_mux     = PC_EXC;
          save_id    = 1'b1;
          save_cause = 1'b1;
          if (fetch_err_q) begin
            exc_cause = 6'd1;  mtval = bus.pc_id_i;
          end else if (illegal_q) begin
            exc_cause = 6'd2;  mtval = bus.instr_i;
          end else if (ecall_q) begin
            exc_cause = 6'd11;
          end else if (store_err_q) begin
            exc_cause = 6'd7;  mtval = bus.lsu_addr_last_i;
          end else begin
            exc_cause = 6'd5;  mtval = bus.lsu_addr_last_i;
          end
        end else if (mret_q) begin
          pc_set       = 1'b1;
          pc_mux       = PC_ERET;
          restore_mret = 1'b1;
          nmi_mode_d   = 1'b0;
        end else if (wfi_q) begin
          state_d = WAIT_SLEEP;
        end
      end
      IRQ_TAKEN: begin
        state_d = DECODE;
        // A source that dropped between decision and entry produces no strobes at all.
        if (handle_irq) begin
          pc_set     = 1'b1;
          pc_mux     = PC_EXC;
          save_if    = 1'b1;
          save_cause = 1'b1;
          irq_ack    = 1'b1;
          if (nmi_take) begin
            exc_cause  = 6'h3F;
            nmi_mode_d = 1'b1;
          end else if (fast_any) begin
            exc_cause = {2'b11, fast_id};
            rr_ptr_d  = fast_id;
          end else if (bus.irq_external_i) begin
            exc_cause = 6'h2B;
          end else if (bus.irq_software_i) begin
            exc_cause = 6'h23;
          end else begin
            exc_cause = 6'h27;
          end
        end
      end
      WAIT_SLEEP: begin
        ctrl_busy = 1'b0;
        instr_req = 1'b0;
        halt_if   = 1'b1;
        flush_id  = 1'b1;
        state_d   = SLEEP;
      end
      SLEEP: begin
        ctrl_busy = 1'b0;
        instr_req = 1'b0;
        halt_if   = 1'b1;
        flush_id  = 1'b1;
        // Wake ignores mie: a masked interrupt still resumes fetch.
        if (irq_std || bus.irq_nm_i) begin
          ctrl_busy = 1'b1;
          state_d   = FIRST_FETCH;
        end
      end
      default: state_d = RESET;
    endcase
  end

  assign bus.ctrl_busy_o         = ctrl_busy;
  assign bus.instr_req_o         = instr_req;
  assign bus.pc_set_o            = pc_set;
  assign bus.pc_mux_o            = pc_mux;
  assign bus.exc_cause_o         = exc_cause;
  assign bus.csr_save_if_o       = save_if;
  assign bus.csr_save_id_o       = save_id;
  assign bus.csr_save_cause_o    = save_cause;
  assign bus.csr_restore_mret_o  = restore_mret;
  assign bus.csr_mtval_o         = mtval;
  assign bus.id_in_ready_o       = ~bus.stall_i & ~halt_if;
  assign bus.instr_valid_clear_o = ~(bus.stall_i | halt_if) | flush_id;
  assign bus.nmi_mode_o          = nmi_mode_q;
  assign bus.irq_ack_o           = irq_ack;
  assign bus.irq_ack_id_o        = exc_cause[4:0];
endmodule

// File: tb/tb_ibex_trap_controller.sv
// Drives a fixed-priority and a round-robin controller (4 fast lines) from one stimulus set;
// trap entries are scored against expectation queues, sequencing is checked directly.
module tb_ibex_trap_controller;
  logic        clk = 1'b0, rst_ni;
  logic        fetch_enable, instr_valid, illegal, ecall, mret, wfi, fetch_err, branch_set, stall;
  logic        load_err, store_err, mie, sw, tmr, ext, nm;
  logic [31:0] lsu_addr, pc_id, instr;
  logic [3:0]  fast;

  int n_tests = 0, n_fail = 0;

  typedef struct { logic [5:0] cause; logic [31:0] mtval; logic irq; } exp_t;
  exp_t       fix_q[$];
  logic [4:0] rr_q[$];

  always #5 clk = ~clk;

  ibex_trap_controller_if #(.NUM_FAST_IRQ(4)) bf ();
  ibex_trap_controller_if #(.NUM_FAST_IRQ(4)) br ();

  assign bf.fetch_enable_i = fetch_enable;   assign br.fetch_enable_i = fetch_enable;
  assign bf.instr_valid_i = instr_valid;     assign br.instr_valid_i = instr_valid;
  assign bf.illegal_insn_i = illegal;        assign br.illegal_insn_i = illegal;
  assign bf.ecall_insn_i = ecall;            assign br.ecall_insn_i = ecall;
  assign bf.mret_insn_i = mret;              assign br.mret_insn_i = mret;
  assign bf.wfi_insn_i = wfi;                assign br.wfi_insn_i = wfi;
  assign bf.instr_fetch_err_i = fetch_err;   assign br.instr_fetch_err_i = fetch_err;
  assign bf.branch_set_i = branch_set;       assign br.branch_set_i = branch_set;
  assign bf.stall_i = stall;                 assign br.stall_i = stall;
  assign bf.load_err_i = load_err;           assign br.load_err_i = load_err;
  assign bf.store_err_i = store_err;         assign br.store_err_i = store_err;
  assign bf.lsu_addr_last_i = lsu_addr;      assign br.lsu_addr_last_i = lsu_addr;
  assign bf.pc_id_i = pc_id;                 assign br.pc_id_i = pc_id;
  assign bf.instr_i = instr;                 assign br.instr_i = instr;
  assign bf.csr_mstatus_mie_i = mie;         assign br.csr_mstatus_mie_i = mie;
  assign bf.irq_software_i = sw;             assign br.irq_software_i = sw;
  assign bf.irq_timer_i = tmr;               assign br.irq_timer_i = tmr;
  assign bf.irq_external_i = ext;            assign br.irq_external_i = ext;
  assign bf.irq_fast_i = fast;               assign br.irq_fast_i = fast;
  assign bf.irq_nm_i = nm;                   assign br.irq_nm_i = nm;

  ibex_trap_controller #(.NUM_FAST_IRQ(4), .FAST_IRQ_RR(1'b0)) u_fix (.clk(clk), .rst_ni(rst_ni), .bus(bf));
  ibex_trap_controller #(.NUM_FAST_IRQ(4), .FAST_IRQ_RR(1'b1)) u_rr  (.clk(clk), .rst_ni(rst_ni), .bus(br));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Scoreboard: every cause strobe / acknowledge must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni === 1'b1) begin
      if (bf.csr_save_cause_o) begin
        chk("fix_entry_expected", 32'(fix_q.size() != 0), 32'd1);
        if (fix_q.size() != 0) begin
          e = fix_q.pop_front();
          chk("fix_cause", 32'(bf.exc_cause_o), 32'(e.cause));
          chk("fix_irq_ack", 32'(bf.irq_ack_o), 32'(e.irq));
          if (e.irq) chk("fix_ack_id", 32'(bf.irq_ack_id_o), 32'(e.cause[4:0]));
          else       chk("fix_mtval", bf.csr_mtval_o, e.mtval);
        end
      end
      if (br.irq_ack_o) begin
        chk("rr_ack_expected", 32'(rr_q.size() != 0), 32'd1);
        if (rr_q.size() != 0) chk("rr_ack_id", 32'(br.irq_ack_id_o), 32'(rr_q.pop_front()));
      end
    end
  end

  // Called in DECODE just after an edge; returns in DECODE just after an edge.
  task automatic run_exc(input string tag, input logic il, ec, fe, se, le,
                         input logic [5:0] cause, input logic [31:0] mtval);
    instr_valid = 1'b1; illegal = il; ecall = ec; fetch_err = fe; store_err = se; load_err = le;
    fix_q.push_back('{cause, mtval, 1'b0});
    @(negedge clk); chk({tag, "_halt"}, 32'(bf.id_in_ready_o), 32'd0);
    tick;
    instr_valid = 1'b0; illegal = 1'b0; ecall = 1'b0; fetch_err = 1'b0; store_err = 1'b0; load_err = 1'b0;
    @(negedge clk);
    chk({tag, "_pc_set"}, 32'(bf.pc_set_o), 32'd1);
    chk({tag, "_pc_mux"}, 32'(bf.pc_mux_o), 32'd2);
    chk({tag, "_save_id"}, 32'(bf.csr_save_id_o), 32'd1);
    tick;
    @(negedge clk);
    chk({tag, "_decode_ready"}, 32'(bf.id_in_ready_o), 32'd1);
    chk({tag, "_decode_pc_set"}, 32'(bf.pc_set_o), 32'd0);
    tick;
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; fetch_enable = 1'b0; instr_valid = 1'b0; illegal = 1'b0; ecall = 1'b0;
    mret = 1'b0; wfi = 1'b0; fetch_err = 1'b0; branch_set = 1'b0; stall = 1'b0;
    load_err = 1'b0; store_err = 1'b0; mie = 1'b0; sw = 1'b0; tmr = 1'b0; ext = 1'b0;
    nm = 1'b0; fast = 4'b0; lsu_addr = 32'h0000_1234; pc_id = 32'h0000_0080; instr = 32'hDEAD_BEEF;

    // Boot
    repeat (2) @(posedge clk);
    #1; @(negedge clk);
    chk("rst_pc_set", 32'(bf.pc_set_o), 32'd1);
    chk("rst_pc_mux", 32'(bf.pc_mux_o), 32'd0);
    chk("rst_instr_req", 32'(bf.instr_req_o), 32'd0);
    tick; rst_ni = 1'b1; fetch_enable = 1'b1;
    @(negedge clk); chk("reset_state_pc_set", 32'(bf.pc_set_o), 32'd1);
    tick; @(negedge clk);
    chk("boot_set_pc_set", 32'(bf.pc_set_o), 32'd1);
    chk("boot_set_pc_mux", 32'(bf.pc_mux_o), 32'd0);
    chk("boot_set_instr_req", 32'(bf.instr_req_o), 32'd1);
    tick; @(negedge clk);
    chk("first_fetch_pc_set", 32'(bf.pc_set_o), 32'd0);
    chk("first_fetch_ready", 32'(bf.id_in_ready_o), 32'd1);
    tick;

    // Branch in DECODE
    branch_set = 1'b1;
    @(negedge clk);
    chk("branch_pc_set", 32'(bf.pc_set_o), 32'd1);
    chk("branch_pc_mux", 32'(bf.pc_mux_o), 32'd1);
    tick; branch_set = 1'b0;

    // Exceptions
    run_exc("illegal", 1, 0, 0, 0, 0, 6'd2, 32'hDEAD_BEEF);
    run_exc("ecall", 0, 1, 0, 0, 0, 6'd11, 32'h0);
    run_exc("fetch_err", 0, 0, 1, 0, 0, 6'd1, 32'h0000_0080);
    run_exc("store_err", 0, 0, 0, 1, 0, 6'd7, 32'h0000_1234);
    run_exc("load_err", 0, 0, 0, 0, 1, 6'd5, 32'h0000_1234);

    // Fast IRQs held: fixed keeps taking 19, round-robin cycles from index 0
    mie = 1'b1; fast = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      fix_q.push_back('{6'h33, 32'h0, 1'b1});
      rr_q.push_back(5'(16 + (i % 4)));
    end
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (br.irq_ack_o) n++;
    end
    chk("rr_ack_count", 32'(n), 32'd5);
    tick; fast = 4'b0; mie = 1'b0;
    @(negedge clk); chk("rr_no_reack", 32'(br.irq_ack_o), 32'd0);
    tick;

    // Fixed priority on 1010; round-robin pointer now at 0, so index 1 next
    mie = 1'b1; fast = 4'b1010;
    fix_q.push_back('{6'h33, 32'h0, 1'b1}); rr_q.push_back(5'd17);
    @(negedge clk); chk("fp_decide_halt", 32'(bf.id_in_ready_o), 32'd0);
    tick; @(negedge clk);
    chk("fp_ack", 32'(bf.irq_ack_o), 32'd1);
    chk("fp_ack_id", 32'(bf.irq_ack_id_o), 32'd19);
    chk("fp_save_if", 32'(bf.csr_save_if_o), 32'd1);
    tick; fast = 4'b0; mie = 1'b0;
    @(negedge clk); chk("fp_single_ack", 32'(bf.irq_ack_o), 32'd0);
    tick;

    // NMI beats software IRQ, then a second NMI is masked until mret
    mie = 1'b1; sw = 1'b1; nm = 1'b1;
    fix_q.push_back('{6'h3F, 32'h0, 1'b1}); rr_q.push_back(5'd31);
    @(negedge clk);
    tick; @(negedge clk); chk("nmi_ack", 32'(bf.irq_ack_o), 32'd1);
    tick; sw = 1'b0; nm = 1'b0; mie = 1'b0;
    @(negedge clk); chk("nmi_mode_set", 32'(bf.nmi_mode_o), 32'd1);
    tick; nm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nmi2_ignored_ack", 32'(bf.irq_ack_o), 32'd0);
      chk("nmi2_ignored_ready", 32'(bf.id_in_ready_o), 32'd1);
      tick;
    end
    nm = 1'b0; instr_valid = 1'b1; mret = 1'b1;
    @(negedge clk);
    tick; instr_valid = 1'b0; mret = 1'b0;
    @(negedge clk);
    chk("mret_pc_set", 32'(bf.pc_set_o), 32'd1);
    chk("mret_pc_mux", 32'(bf.pc_mux_o), 32'd3);
    chk("mret_restore", 32'(bf.csr_restore_mret_o), 32'd1);
    tick; @(negedge clk); chk("mret_nmi_clear", 32'(bf.nmi_mode_o), 32'd0);
    tick; nm = 1'b1;
    fix_q.push_back('{6'h3F, 32'h0, 1'b1}); rr_q.push_back(5'd31);
    @(negedge clk);
    tick; @(negedge clk); chk("nmi3_ack", 32'(bf.irq_ack_o), 32'd1);
    tick; nm = 1'b0;

    // WFI sleep, masked timer wake
    instr_valid = 1'b1; wfi = 1'b1;
    @(negedge clk);
    tick; instr_valid = 1'b0; wfi = 1'b0;
    @(negedge clk); chk("wfi_flush_busy", 32'(bf.ctrl_busy_o), 32'd1);
    tick; @(negedge clk);
    chk("wait_sleep_busy", 32'(bf.ctrl_busy_o), 32'd0);
    chk("wait_sleep_req", 32'(bf.instr_req_o), 32'd0);
    tick; @(negedge clk);
    chk("sleep_busy", 32'(bf.ctrl_busy_o), 32'd0);
    tick; tmr = 1'b1;
    @(negedge clk); chk("wake_busy", 32'(bf.ctrl_busy_o), 32'd1);
    tick; @(negedge clk);
    chk("wake_ff_req", 32'(bf.instr_req_o), 32'd1);
    chk("wake_ff_ready", 32'(bf.id_in_ready_o), 32'd1);
    chk("wake_ff_no_ack", 32'(bf.irq_ack_o), 32'd0);
    tick; tmr = 1'b0;

    // Reset while sleeping
    instr_valid = 1'b1; wfi = 1'b1;
    @(negedge clk);
    tick; instr_valid = 1'b0; wfi = 1'b0;
    tick; tick;
    @(negedge clk); chk("sleep2_busy", 32'(bf.ctrl_busy_o), 32'd0);
    tick; rst_ni = 1'b0;
    @(negedge clk); chk("sleep_pre_edge_busy", 32'(bf.ctrl_busy_o), 32'd0);
    tick; @(negedge clk);
    chk("sleep_rst_pc_set", 32'(bf.pc_set_o), 32'd1);
    chk("sleep_rst_instr_req", 32'(bf.instr_req_o), 32'd0);
    chk("sleep_rst_busy", 32'(bf.ctrl_busy_o), 32'd1);
    chk("sleep_rst_nmi_mode", 32'(bf.nmi_mode_o), 32'd0);

    chk("fix_queue_drained", 32'(fix_q.size()), 32'd0);
    chk("rr_queue_drained", 32'(rr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
